imem_mem_arbiter: RTL and testbench
===================================

Name: imem_mem_arbiter

Overview:
- Sole owner of the processor-to-memory instruction port.
- Arbitrates each cycle between icache demand misses and prefetcher requests.
- Tracks every accepted request by memory tag and returns fills marked demand or prefetch.
- Filters prefetches that duplicate an in-flight line, and promotes an in-flight prefetch to demand when the icache misses on that line.

Parameters:
ADDR_W, 64, byte address width (PC width)
TAG_W, 4, memory tag width; tag 0 means "not accepted / no completion"
MAX_OUTST, 8, max outstanding requests (1..2^TAG_W-1)
PF_RESERVE, 2, tracker entries kept free for demand; a prefetch issues only if outstanding < MAX_OUTST-PF_RESERVE

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
icache_req_valid  in  1  demand miss request
icache_req_addr  in  ADDR_W  demand line address (8-byte aligned)
pf_request_valid  in  1  prefetch request
pf_requested_addr  in  ADDR_W  prefetch line address
mem2proc_response  in  TAG_W  tag of request accepted this cycle; 0 = rejected
mem2proc_tag  in  TAG_W  tag completing this cycle; 0 = none
mem2proc_data  in  64  completion data
proc2mem_command  out  2  0 = NONE, 1 = LOAD
proc2mem_addr  out  ADDR_W  request address
icache_grant  out  1  demand request satisfied this cycle (issued+accepted, or merged)
icache_pf_stall  out  1  prefetch not consumed this cycle
fill_valid  out  1  completion for tracked tag
fill_addr  out  ADDR_W  address of completing line
fill_is_pf  out  1  completing line is still prefetch-only
fill_data  out  64  = mem2proc_data
outst_count  out  $clog2(MAX_OUTST+1)  valid tracker entries

Behaviour:
Tracker:
- Table indexed by tag (1..2^TAG_W-1): valid, addr, is_pf.
- outst_count = number of valid entries.

Arbitration (combinational, same cycle as memory response):
- Demand hit in tracker (addr match, valid): no issue; icache_grant=1; entry is_pf cleared at edge.
- Demand miss in tracker, outstanding < MAX_OUTST: proc2mem_command=LOAD, proc2mem_addr=icache_req_addr. icache_grant = (mem2proc_response != 0).
- Demand valid, not merged: prefetch never issues that cycle; icache_pf_stall=1.
- Demand absent:
  - Prefetch whose addr hits tracker: dropped; icache_pf_stall=0; no issue.
  - Prefetch otherwise: issues if outstanding < MAX_OUTST-PF_RESERVE; icache_pf_stall = !(issued && mem2proc_response != 0).
- Prefetch equal to demand address in the same cycle: demand issues; prefetch stalled (it is dropped next cycle by the tracker hit).
- Nothing issued: proc2mem_command=NONE, proc2mem_addr=0.

Allocation:
- Nonzero mem2proc_response while issuing: entry[response] set valid, with addr and is_pf = (issued request was prefetch).

Completion:
- mem2proc_tag != 0 and entry valid: fill_valid=1, fill_addr and fill_is_pf from entry, same cycle. Entry cleared at the edge.
- Tag 0 or invalid entry: ignored; fill_valid=0.

Simultaneous events:
- Completion of tag T and allocation of T in the same cycle: allocation wins; entry ends valid with new contents.
- Demand merge onto the entry completing that cycle: fill_is_pf=0 that cycle.

Reset (asynchronous):
- All entries invalid; outst_count=0.
- Outputs: command NONE, addr 0, grants 0, fill_valid 0, icache_pf_stall = pf_request_valid.
- Reset asserted mid-flight discards all tracking; later completions of old tags are ignored.

Widths:
- Address compare is full ADDR_W equality.
- outst_count saturates by construction; no wrap.

Test Plan:
1. Demand 0x100, response 3 -> LOAD 0x100, icache_grant=1. Later mem2proc_tag=3 -> fill_valid=1, fill_addr=0x100, fill_is_pf=0, outst_count back to 0.
2. Demand 0x200 and prefetch 0x208 in the same cycle -> LOAD 0x200 only, icache_pf_stall=1. Next cycle prefetch alone, response 5 -> LOAD 0x208, stall=0.
3. Prefetch 0x300 accepted tag 2; then demand 0x300 -> no LOAD, icache_grant=1. Completion tag 2 -> fill_is_pf=0.
4. Prefetch 0x300 again while tag 2 is in flight -> no LOAD, icache_pf_stall=0 (dropped).
5. Six outstanding (MAX_OUTST=8, PF_RESERVE=2), prefetch -> stall=1, no LOAD. Demand -> issues. At 8 outstanding, demand -> no LOAD, grant=0.
6. Response 0 on demand -> grant=0, no allocation. Assert reset with 3 outstanding, then completion of tag 1 -> fill_valid=0, outst_count=0.

Source files
------------

// File: rtl/imem_mem_arbiter.sv
// Instruction-port memory arbiter: picks icache demand misses over prefetches, tracks in-flight
// requests by memory tag, filters duplicate prefetches and promotes prefetches hit by demand.
module imem_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned MAX_OUTST  = 8,
  parameter int unsigned PF_RESERVE = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               icache_req_valid,
  input  logic [ADDR_W-1:0]                  icache_req_addr,
  input  logic                               pf_request_valid,
  input  logic [ADDR_W-1:0]                  pf_requested_addr,
  input  logic [TAG_W-1:0]                   mem2proc_response,
  input  logic [TAG_W-1:0]                   mem2proc_tag,
  input  logic [63:0]                        mem2proc_data,
  output logic [1:0]                         proc2mem_command,
  output logic [ADDR_W-1:0]                  proc2mem_addr,
  output logic                               icache_grant,
  output logic                               icache_pf_stall,
  output logic                               fill_valid,
  output logic [ADDR_W-1:0]                  fill_addr,
  output logic                               fill_is_pf,
  output logic [63:0]                        fill_data,
  output logic [$clog2(MAX_OUTST+1)-1:0]     outst_count
);

  localparam int unsigned NumEnt = 2 ** TAG_W;
  localparam int unsigned CntW   = $clog2(MAX_OUTST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTST);
  localparam logic [CntW-1:0] PfCnt  = CntW'(MAX_OUTST - PF_RESERVE);
  localparam logic [1:0] CmdNone = 2'd0;
  localparam logic [1:0] CmdLoad = 2'd1;

  // Entry 0 is never allocated: tag 0 means "no tag".
  logic [NumEnt-1:0] valid_q, valid_d;
  logic [NumEnt-1:0] is_pf_q, is_pf_d;
  logic [ADDR_W-1:0] addr_q [NumEnt];
  logic [ADDR_W-1:0] addr_d [NumEnt];

  logic [CntW-1:0]   cnt;
  logic              dem_hit, pf_hit, merge;
  logic [TAG_W-1:0]  dem_idx;
  logic              issue, issue_pf;
  logic [ADDR_W-1:0] iss_addr;
  logic              accepted;

  always_comb begin
    cnt     = '0;
    dem_hit = 1'b0;
    dem_idx = '0;
    pf_hit  = 1'b0;
    for (int i = 1; i < NumEnt; i++) begin
      cnt = cnt + CntW'(valid_q[i]);
      if (valid_q[i] && addr_q[i] == icache_req_addr) begin
        dem_hit = 1'b1;
        dem_idx = TAG_W'(i);
      end
      if (valid_q[i] && addr_q[i] == pf_requested_addr) pf_hit = 1'b1;
    end
  end

  assign outst_count = cnt;
  assign accepted    = mem2proc_response != '0;

  always_comb begin
    issue           = 1'b0;
    issue_pf        = 1'b0;
    icache_grant    = 1'b0;
    icache_pf_stall = pf_request_valid;
    if (!reset) begin
      if (icache_req_valid) begin
        if (dem_hit) begin
          icache_grant = 1'b1;
        end else if (cnt < MaxCnt) begin
          issue        = 1'b1;
          icache_grant = accepted;
        end
      end else if (pf_request_valid) begin
        if (pf_hit) begin
          icache_pf_stall = 1'b0;
        end else if (cnt < PfCnt) begin
          issue           = 1'b1;
          issue_pf        = 1'b1;
          icache_pf_stall = !accepted;
        end
      end
    end
    iss_addr         = issue ? (issue_pf ? pf_requested_addr : icache_req_addr) : '0;
    proc2mem_command = issue ? CmdLoad : CmdNone;
    proc2mem_addr    = iss_addr;
  end

  assign merge = !reset && icache_req_valid && dem_hit;

  always_comb begin
    fill_valid = !reset && (mem2proc_tag != '0) && valid_q[mem2proc_tag];
    fill_addr  = fill_valid ? addr_q[mem2proc_tag] : '0;
    // A demand merging onto the completing line turns this fill into a demand fill.
    fill_is_pf = fill_valid && is_pf_q[mem2proc_tag] && !(merge && dem_idx == mem2proc_tag);
    fill_data  = mem2proc_data;
  end

  always_comb begin
    valid_d = valid_q;
    is_pf_d = is_pf_q;
    addr_d  = addr_q;
    if (merge) is_pf_d[dem_idx] = 1'b0;
    if (fill_valid) valid_d[mem2proc_tag] = 1'b0;
    // Allocation is applied last so it wins over a same-tag completion.
    if (issue && accepted) begin
      valid_d[mem2proc_response] = 1'b1;
      is_pf_d[mem2proc_response] = issue_pf;
      addr_d[mem2proc_response]  = iss_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      is_pf_q <= '0;
      addr_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      is_pf_q <= is_pf_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_imem_mem_arbiter.sv
// Directed bench for imem_mem_arbiter; accepted requests are recorded in a fill scoreboard
// and matched against completions.
module tb_imem_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_req_valid;
  logic [63:0] icache_req_addr;
  logic        pf_request_valid;
  logic [63:0] pf_requested_addr;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic        icache_grant;
  logic        icache_pf_stall;
  logic        fill_valid;
  logic [63:0] fill_addr;
  logic        fill_is_pf;
  logic [63:0] fill_data;
  logic [3:0]  outst_count;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] addr;
    logic        pf;
  } fill_t;

  fill_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  imem_mem_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .pf_request_valid  (pf_request_valid),
    .pf_requested_addr (pf_requested_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_tag      (mem2proc_tag),
    .mem2proc_data     (mem2proc_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .icache_grant      (icache_grant),
    .icache_pf_stall   (icache_pf_stall),
    .fill_valid        (fill_valid),
    .fill_addr         (fill_addr),
    .fill_is_pf        (fill_is_pf),
    .fill_data         (fill_data),
    .outst_count       (outst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus after the falling edge and let it settle.
  task automatic drive(input logic dv, input logic [63:0] da, input logic pv,
                       input logic [63:0] pa, input logic [3:0] resp, input logic [3:0] tg);
    @(negedge clk);
    icache_req_valid  = dv;
    icache_req_addr   = da;
    pf_request_valid  = pv;
    pf_requested_addr = pa;
    mem2proc_response = resp;
    mem2proc_tag      = tg;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd0);
  endtask

  task automatic push(input logic [3:0] tg, input logic [63:0] a, input logic pf);
    fill_t e;
    e.tag  = tg;
    e.addr = a;
    e.pf   = pf;
    sb.push_back(e);
  endtask

  task automatic promote(input logic [3:0] tg);
    foreach (sb[i]) if (sb[i].tag == tg) sb[i].pf = 1'b0;
  endtask

  task automatic complete(input logic [3:0] tg);
    int idx = -1;
    drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, tg);
    foreach (sb[i]) if (sb[i].tag == tg) idx = i;
    n_tests++;
    assert (idx >= 0) else begin
      n_fail++;
      $error("FAIL sb_lookup: observed no entry expected entry for tag %0d", tg);
    end
    chk("fill_valid", 64'(fill_valid), 64'd1);
    chk("fill_data", fill_data, mem2proc_data);
    if (idx >= 0) begin
      chk("fill_addr", fill_addr, sb[idx].addr);
      chk("fill_is_pf", 64'(fill_is_pf), 64'(sb[idx].pf));
      sb.delete(idx);
    end
  endtask

  initial begin
    reset = 1'b1;
    icache_req_valid = 1'b0; icache_req_addr = '0;
    pf_request_valid = 1'b1; pf_requested_addr = 64'h80;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk); #1;
    chk("rst_cmd", 64'(proc2mem_command), 64'd0);
    chk("rst_addr", proc2mem_addr, 64'h0);
    chk("rst_grant", 64'(icache_grant), 64'd0);
    chk("rst_fill", 64'(fill_valid), 64'd0);
    chk("rst_stall", 64'(icache_pf_stall), 64'd1);
    chk("rst_outst", 64'(outst_count), 64'd0);
    reset = 1'b0;

    // Simple demand miss and its fill.
    drive(1'b1, 64'h100, 1'b0, 64'h0, 4'd3, 4'd0);
    chk("t1_cmd", 64'(proc2mem_command), 64'd1);
    chk("t1_addr", proc2mem_addr, 64'h100);
    chk("t1_grant", 64'(icache_grant), 64'd1);
    push(4'd3, 64'h100, 1'b0);
    idle();
    chk("t1_outst", 64'(outst_count), 64'd1);
    complete(4'd3);
    mem2proc_data = 64'h1234_5678_9ABC_DEF0;
    idle();
    chk("t1_outst0", 64'(outst_count), 64'd0);

    // Demand beats prefetch; prefetch goes alone next cycle.
    drive(1'b1, 64'h200, 1'b1, 64'h208, 4'd7, 4'd0);
    chk("t2_cmd", 64'(proc2mem_command), 64'd1);
    chk("t2_addr", proc2mem_addr, 64'h200);
    chk("t2_stall", 64'(icache_pf_stall), 64'd1);
    push(4'd7, 64'h200, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 64'h208, 4'd5, 4'd0);
    chk("t2_pfcmd", 64'(proc2mem_command), 64'd1);
    chk("t2_pfaddr", proc2mem_addr, 64'h208);
    chk("t2_pfstall", 64'(icache_pf_stall), 64'd0);
    push(4'd5, 64'h208, 1'b1);
    complete(4'd7);
    complete(4'd5);

    // Demand merges onto in-flight prefetch; duplicate prefetch dropped.
    drive(1'b0, 64'h0, 1'b1, 64'h300, 4'd2, 4'd0);
    chk("t3_pfcmd", 64'(proc2mem_command), 64'd1);
    push(4'd2, 64'h300, 1'b1);
    drive(1'b1, 64'h300, 1'b0, 64'h0, 4'd0, 4'd0);
    chk("t3_cmd", 64'(proc2mem_command), 64'd0);
    chk("t3_grant", 64'(icache_grant), 64'd1);
    promote(4'd2);
    drive(1'b0, 64'h0, 1'b1, 64'h300, 4'd0, 4'd0);
    chk("t4_cmd", 64'(proc2mem_command), 64'd0);
    chk("t4_stall", 64'(icache_pf_stall), 64'd0);
    complete(4'd2);
    idle();
    chk("t3_outst0", 64'(outst_count), 64'd0);

    // Occupancy limits for prefetch and demand.
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 64'h0, 1'b1, 64'h1000 + 64'(8 * i), 4'(i), 4'd0);
      chk("t5_pfissue", 64'(proc2mem_command), 64'd1);
      push(4'(i), 64'h1000 + 64'(8 * i), 1'b1);
    end
    idle();
    chk("t5_outst6", 64'(outst_count), 64'd6);
    drive(1'b0, 64'h0, 1'b1, 64'h2000, 4'd9, 4'd0);
    chk("t5_pfcmd", 64'(proc2mem_command), 64'd0);
    chk("t5_pfstall", 64'(icache_pf_stall), 64'd1);
    drive(1'b1, 64'h3000, 1'b0, 64'h0, 4'd7, 4'd0);
    chk("t5_dcmd7", 64'(proc2mem_command), 64'd1);
    chk("t5_grant7", 64'(icache_grant), 64'd1);
    push(4'd7, 64'h3000, 1'b0);
    drive(1'b1, 64'h3008, 1'b0, 64'h0, 4'd8, 4'd0);
    chk("t5_grant8", 64'(icache_grant), 64'd1);
    push(4'd8, 64'h3008, 1'b0);
    idle();
    chk("t5_outst8", 64'(outst_count), 64'd8);
    drive(1'b1, 64'h3010, 1'b0, 64'h0, 4'd9, 4'd0);
    chk("t5_fullcmd", 64'(proc2mem_command), 64'd0);
    chk("t5_fullgrant", 64'(icache_grant), 64'd0);
    idle();
    chk("t5_noalloc", 64'(outst_count), 64'd8);
    while (sb.size() > 0) complete(sb[0].tag);
    idle();
    chk("t5_outst0", 64'(outst_count), 64'd0);

    // Completion and re-allocation of the same tag in one cycle.
    drive(1'b1, 64'h4000, 1'b0, 64'h0, 4'd1, 4'd0);
    chk("sim_grant", 64'(icache_grant), 64'd1);
    drive(1'b1, 64'h4008, 1'b0, 64'h0, 4'd1, 4'd1);
    chk("sim_fill", 64'(fill_valid), 64'd1);
    chk("sim_faddr", fill_addr, 64'h4000);
    chk("sim_cmd", 64'(proc2mem_command), 64'd1);
    push(4'd1, 64'h4008, 1'b0);
    idle();
    chk("sim_outst", 64'(outst_count), 64'd1);
    complete(4'd1);

    // Demand merge onto the line completing this very cycle.
    drive(1'b0, 64'h0, 1'b1, 64'h5000, 4'd4, 4'd0);
    drive(1'b1, 64'h5000, 1'b0, 64'h0, 4'd0, 4'd4);
    chk("mrg_grant", 64'(icache_grant), 64'd1);
    chk("mrg_cmd", 64'(proc2mem_command), 64'd0);
    chk("mrg_fill", 64'(fill_valid), 64'd1);
    chk("mrg_pf", 64'(fill_is_pf), 64'd0);
    idle();
    chk("mrg_outst", 64'(outst_count), 64'd0);

    // Rejected demand, then reset with requests in flight.
    drive(1'b1, 64'h600, 1'b0, 64'h0, 4'd0, 4'd0);
    chk("t6_cmd", 64'(proc2mem_command), 64'd1);
    chk("t6_grant", 64'(icache_grant), 64'd0);
    idle();
    chk("t6_noalloc", 64'(outst_count), 64'd0);
    for (int i = 1; i <= 3; i++) drive(1'b1, 64'h700 + 64'(8 * i), 1'b0, 64'h0, 4'(i), 4'd0);
    idle();
    chk("t6_outst3", 64'(outst_count), 64'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rst_outst", 64'(outst_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd1);
    chk("t6_oldtag", 64'(fill_valid), 64'd0);
    chk("t6_outst0", 64'(outst_count), 64'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
